pci_arbiter: RTL and testbench
==============================

// Module: pci_arbiter
// PURPOSE
//   Central PCI bus arbiter; sits upstream of every PCI Device and drives their GNT inputs.
//   Samples each device's active-low REQ and watches the shared FRAME/IRDY lines to tell when the bus is idle.
//   Issues one active-low GNT at a time using round-robin priority.
//   Revokes GNT if the granted master never starts a transaction.
// PARAMETERS
//   NUM_MASTERS  3   number of REQ/GNT pairs (devices A, B, C)
//   GNT_TIMEOUT  16  cycles GNT may stay low without FRAME falling before it is revoked (>=2)
// PORTS
//   clk        in   1            bus clock; all state changes on posedge
//   rst        in   1            asynchronous, active-high reset
//   REQ        in   NUM_MASTERS  active-low requests, bit i = device i
//   FRAME      in   1            shared FRAME, active low; any value other than 0 (incl. z/x) = deasserted
//   IRDY       in   1            shared IRDY, active low; same rule as FRAME
//   GNT        out  NUM_MASTERS  active-low grants, registered; at most one bit low
//   bus_owner  out  $clog2(NUM_MASTERS)  index of current/last granted master, registered
//   bus_busy   out  1            1 while in GRANTED or BUSY
//   gnt_timeout out 1            one-cycle pulse when a grant is revoked by timeout
// BEHAVIOUR
//   Reset (async, immediate): GNT='1, bus_owner=0, bus_busy=0, gnt_timeout=0, state=IDLE, rr_ptr=0, timer=0.
//   Reset mid-transaction drops GNT at once; no recovery of the interrupted transfer.
//   idle_bus = (FRAME!==0) && (IRDY!==0). All inputs are sampled on posedge clk.
//   FSM states: IDLE, GRANTED, BUSY, TURNAROUND.
//   IDLE:
//     - if idle_bus and any REQ[i]==0: pick the first requester scanning rr_ptr, rr_ptr+1, ... mod NUM_MASTERS.
//     - GNT[pick]<=0, bus_owner<=pick, timer<=0, go to GRANTED.
//     - Grant latency: 1 edge (REQ seen low at edge T, GNT low after T).
//     - No requester, or bus not idle: stay in IDLE.
//   GRANTED:
//     - FRAME==0 sampled -> BUSY; GNT is held.
//     - else REQ[owner]==1 (request withdrawn) -> GNT<='1, rr_ptr<=owner+1, go to TURNAROUND.
//     - else timer==GNT_TIMEOUT-1 -> GNT<='1, gnt_timeout<=1 for one cycle, rr_ptr<=owner+1, go to TURNAROUND.
//     - otherwise timer++.
//     - If FRAME falls and the timeout expire on the same edge, FRAME wins and the grant is kept.
//   BUSY:
//     - GNT[owner] stays low for the whole transaction; REQ changes are ignored.
//     - when idle_bus is sampled: GNT<='1, rr_ptr<=owner+1 mod NUM_MASTERS, go to TURNAROUND.
//   TURNAROUND: exactly one cycle with all GNT high (bus turnaround), then IDLE.
//     - Minimum gap between two grants is therefore 2 edges.
//   Wrap-around: rr_ptr = NUM_MASTERS-1 advances to 0; the last owner gets lowest priority next round.
//   Simultaneous requests: resolved purely by rr_ptr order; same-cycle arrivals have no extra tie-break.
//   Invariants: never more than one GNT bit low; GNT never changes while FRAME==0.
//   bus_busy = (state==GRANTED || state==BUSY), registered with state.
// STRUCTURE
//   pci_pkg:
//     - arbiter state encoding.
//     - ASSERTED=1'b0 / DEASSERTED=1'b1 constants for REQ/GNT/FRAME/IRDY.
//     - C_BE command codes (WRITE 4'b0100, READ 4'b0001), shared with the device.
//     - device address constants (8'hAD, 8'hBD, 8'hCD).
//   Sub-module rr_priority_pick:
//     - combinational; inputs req_n[NUM_MASTERS] and ptr.
//     - outputs any_req and pick_idx.
//     - implemented as a rotate, find-first-zero, then un-rotate.
//   The top holds the FSM, timer, rr_ptr and output registers.
// TESTING
//   1 Reset, then REQ=3'b110 with FRAME/IRDY high -> GNT=3'b110 one edge later; bus_owner=0; bus_busy=1.
//   2 REQ=3'b000 from reset:
//       - grant order is 0,1,2,0.
//       - each master drives FRAME low 1 cycle after GNT and releases FRAME/IRDY after 3 cycles.
//       - every transaction is followed by 1 TURNAROUND cycle with GNT=3'b111.
//   3 Granted master 1 never drives FRAME:
//       - GNT[1] is revoked after 16 cycles and gnt_timeout pulses once.
//       - next grant goes to 2 if REQ[2]=0, else to 0.
//   4 Device 2 raises REQ while FRAME is low:
//       - GNT[2] stays low until FRAME and IRDY are both high.
//       - it is released the edge after, with no glitch on the other GNT bits.
//   5 rst pulsed mid-BUSY (not clock-aligned) -> GNT=3'b111 immediately; after release, REQ=3'b011 -> GNT=3'b011 (rr_ptr reset to 0).
//   6 FRAME/IRDY left at z with REQ=3'b101:
//       - z is treated as idle, GNT=3'b101.
//       - continuous assertion checks: $countones(~GNT)<=1, and GNT stable while FRAME==0.

Source files
------------

// File: rtl/pci_pkg.sv
// Shared PCI definitions for the arbiter and the bus devices.
//   arb_state_e   : arbiter FSM encoding
//   ASSERTED/DEASSERTED : levels of the active-low REQ/GNT/FRAME/IRDY lines
//   CBE_*         : C/BE command codes used by the devices
//   ADDR_DEV_*    : device base addresses
package pci_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_GRANTED    = 2'd1,
    ST_BUSY       = 2'd2,
    ST_TURNAROUND = 2'd3
  } arb_state_e;

  localparam logic ASSERTED   = 1'b0;
  localparam logic DEASSERTED = 1'b1;

  localparam logic [3:0] CBE_WRITE = 4'b0100;
  localparam logic [3:0] CBE_READ  = 4'b0001;

  localparam logic [7:0] ADDR_DEV_A = 8'hAD;
  localparam logic [7:0] ADDR_DEV_B = 8'hBD;
  localparam logic [7:0] ADDR_DEV_C = 8'hCD;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin requester selection (combinational).
//   req_n    : active-low requests, bit i = master i
//   ptr      : highest-priority master this round
//   any_req  : at least one request asserted
//   pick_idx : first requester found scanning ptr, ptr+1, ... (mod NUM_MASTERS)
module rr_priority_pick import pci_pkg::*; #(
  parameter int NUM_MASTERS = 3,
  parameter int PW          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic [NUM_MASTERS-1:0] req_n,
  input  logic [PW-1:0]          ptr,
  output logic                   any_req,
  output logic [PW-1:0]          pick_idx
);

  // Modular add; both operands are below NUM_MASTERS so one subtraction is enough.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (PW+1)'(NUM_MASTERS)) s = s - (PW+1)'(NUM_MASTERS);
    return s[PW-1:0];
  endfunction

  logic [NUM_MASTERS-1:0] rot;
  logic [PW-1:0]          first;

  // Rotate so that bit 0 is the master at ptr.
  always_comb begin
    rot = '1;
    for (int k = 0; k < NUM_MASTERS; k++) rot[k] = req_n[wrap_add(ptr, PW'(k))];
  end

  // Find first asserted request; scanning downward leaves the lowest index.
  always_comb begin
    any_req = 1'b0;
    first   = '0;
    for (int k = NUM_MASTERS-1; k >= 0; k--) begin
      if (rot[k] == ASSERTED) begin
        any_req = 1'b1;
        first   = PW'(k);
      end
    end
  end

  // Un-rotate back to a master index.
  assign pick_idx = wrap_add(ptr, first);

endmodule

// File: rtl/pci_arbiter.sv
// Central PCI bus arbiter: one active-low GNT at a time, round-robin priority,
// grant revoked if the owner never starts a transaction.
//   clk, rst    : bus clock, asynchronous active-high reset
//   REQ         : active-low requests (bit i = device i)
//   FRAME, IRDY : shared active-low bus lines; anything but a solid 0 is idle
//   GNT         : active-low grants, registered, at most one low
//   bus_owner   : index of the current / last granted master
//   bus_busy    : high in GRANTED and BUSY
//   gnt_timeout : one-cycle pulse when a grant is revoked by timeout
module pci_arbiter import pci_pkg::*; #(
  parameter  int NUM_MASTERS = 3,
  parameter  int GNT_TIMEOUT = 16,
  localparam int OW          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  localparam int TW          = $clog2(GNT_TIMEOUT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] REQ,
  input  logic                   FRAME,
  input  logic                   IRDY,
  output logic [NUM_MASTERS-1:0] GNT,
  output logic [OW-1:0]          bus_owner,
  output logic                   bus_busy,
  output logic                   gnt_timeout
);

  arb_state_e             state, state_d;
  logic [TW-1:0]          timer, timer_d;
  logic [OW-1:0]          rr_ptr, rr_ptr_d, owner_d, owner_inc, pick_idx;
  logic [NUM_MASTERS-1:0] gnt_d;
  logic                   busy_d, tmo_d, any_req;
  logic                   frame_low, irdy_low, idle_bus;
  logic                   grant_ev, release_ev, timeout_ev;

  // Case equality so a floating (z/x) line reads as released.
  assign frame_low = (FRAME === ASSERTED);
  assign irdy_low  = (IRDY  === ASSERTED);
  assign idle_bus  = !frame_low && !irdy_low;

  // The last owner drops to lowest priority after its grant ends.
  assign owner_inc = (bus_owner == OW'(NUM_MASTERS-1)) ? '0 : bus_owner + 1'b1;

  rr_priority_pick #(.NUM_MASTERS(NUM_MASTERS), .PW(OW)) u_pick (
    .req_n    (REQ),
    .ptr      (rr_ptr),
    .any_req  (any_req),
    .pick_idx (pick_idx)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      GNT         <= '1;
      bus_owner   <= '0;
      bus_busy    <= 1'b0;
      gnt_timeout <= 1'b0;
      rr_ptr      <= '0;
      timer       <= '0;
    end else begin
      state       <= state_d;
      GNT         <= gnt_d;
      bus_owner   <= owner_d;
      bus_busy    <= busy_d;
      gnt_timeout <= tmo_d;
      rr_ptr      <= rr_ptr_d;
      timer       <= timer_d;
    end
  end

  // Next state. In GRANTED, FRAME falling beats both withdrawal and timeout.
  always_comb begin
    state_d    = state;
    grant_ev   = 1'b0;
    release_ev = 1'b0;
    timeout_ev = 1'b0;
    case (state)
      ST_IDLE: begin
        if (idle_bus && any_req) begin
          state_d  = ST_GRANTED;
          grant_ev = 1'b1;
        end
      end
      ST_GRANTED: begin
        if (frame_low) begin
          state_d = ST_BUSY;
        end else if (REQ[bus_owner] == DEASSERTED) begin
          state_d    = ST_TURNAROUND;
          release_ev = 1'b1;
        end else if (timer == TW'(GNT_TIMEOUT-1)) begin
          state_d    = ST_TURNAROUND;
          release_ev = 1'b1;
          timeout_ev = 1'b1;
        end
      end
      ST_BUSY: begin
        if (idle_bus) begin
          state_d    = ST_TURNAROUND;
          release_ev = 1'b1;
        end
      end
      ST_TURNAROUND: state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Register inputs derived from the transition taken.
  always_comb begin
    gnt_d    = GNT;
    owner_d  = bus_owner;
    rr_ptr_d = rr_ptr;
    timer_d  = timer;
    tmo_d    = timeout_ev;
    busy_d   = (state_d == ST_GRANTED) || (state_d == ST_BUSY);
    if (grant_ev) begin
      gnt_d           = '1;
      gnt_d[pick_idx] = ASSERTED;
      owner_d         = pick_idx;
      timer_d         = '0;
    end else if (release_ev) begin
      gnt_d    = '1;
      rr_ptr_d = owner_inc;
    end else if (state == ST_GRANTED && state_d == ST_GRANTED) begin
      timer_d = timer + 1'b1;
    end
  end

endmodule

// File: tb/tb_pci_arbiter.sv
module tb_pci_arbiter;
  localparam int NM  = 3;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [NM-1:0] req_in;
  logic          frame_drv, irdy_drv, lines_en;
  wire           frame_w, irdy_w;
  logic [NM-1:0] GNT;
  logic [1:0]    bus_owner;
  logic          bus_busy, gnt_timeout;

  // Released lines float and are pulled to the idle level.
  assign frame_w = lines_en ? frame_drv : 1'bz;
  assign irdy_w  = lines_en ? irdy_drv  : 1'bz;
  pullup (frame_w);
  pullup (irdy_w);

  always #5 clk = ~clk;

  pci_arbiter #(.NUM_MASTERS(NM), .GNT_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .REQ(req_in), .FRAME(frame_w), .IRDY(irdy_w),
    .GNT(GNT), .bus_owner(bus_owner), .bus_busy(bus_busy), .gnt_timeout(gnt_timeout)
  );

  typedef struct {
    logic [NM-1:0] gnt;
    logic [1:0]    owner;
    logic          busy;
    logic          tmo;
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: who holds the bus, whether the transfer has started,
  // how long the grant has been idle, and whether a turnaround gap is due.
  int m_owner, m_last, m_ptr, m_wait;
  bit m_xfer, m_gap, m_tmo;

  // Device behaviour
  logic [NM-1:0] req_v, silent;
  bit            dev_auto, rand_len;
  int            frame_left, irdy_left;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function void model_reset();
    m_owner = -1; m_last = 0; m_ptr = 0; m_wait = 0;
    m_xfer = 0; m_gap = 0; m_tmo = 0;
  endfunction

  function void release_grant();
    m_ptr   = (m_owner + 1) % NM;
    m_owner = -1;
    m_gap   = 1;
  endfunction

  function void model_step(input logic [NM-1:0] req, input bit idle, input bit frame_low);
    int c;
    m_tmo = 0;
    if (m_gap) m_gap = 0;
    else if (m_owner < 0) begin
      if (idle) begin
        for (int k = 0; k < NM; k++) begin
          c = (m_ptr + k) % NM;
          if (req[c] == 1'b0) begin
            m_owner = c; m_last = c; m_wait = 0; m_xfer = 0;
            break;
          end
        end
      end
    end else if (m_xfer) begin
      if (idle) release_grant();
    end else if (frame_low) m_xfer = 1;
    else if (req[m_owner] == 1'b1) release_grant();
    else if (m_wait == TMO-1) begin release_grant(); m_tmo = 1; end
    else m_wait++;
  endfunction

  function logic [NM-1:0] exp_gnt();
    logic [NM-1:0] g;
    g = '1;
    if (m_owner >= 0) g[m_owner] = 1'b0;
    return g;
  endfunction

  // One bus cycle: devices react on the falling edge, model advances on the rising edge.
  task automatic step();
    int len;
    exp_t e;
    @(negedge clk);
    if (dev_auto) begin
      if (m_owner >= 0 && !m_xfer && !silent[m_owner] && frame_left == 0 && irdy_left == 0) begin
        len        = rand_len ? int'($urandom_range(1, 4)) : 3;
        frame_left = len;
        irdy_left  = len + (rand_len ? int'($urandom_range(0, 1)) : 0);
      end
      frame_drv = (frame_left > 0) ? 1'b0 : 1'b1;
      irdy_drv  = (irdy_left  > 0) ? 1'b0 : 1'b1;
      if (frame_left > 0) frame_left--;
      if (irdy_left  > 0) irdy_left--;
    end
    req_in = req_v;
    @(posedge clk);
    if (rst) model_reset();
    else model_step(req_in, (frame_w !== 1'b0) && (irdy_w !== 1'b0), frame_w === 1'b0);
    e.gnt = exp_gnt(); e.owner = 2'(m_last); e.busy = (m_owner >= 0); e.tmo = m_tmo;
    exp_q.push_back(e);
  endtask

  // Reset raised dly time units after a rising edge, i.e. off the clock.
  task automatic async_reset(input int dly);
    #(dly);
    exp_q.delete();
    rst = 1'b1;
    #1;
    check("rst_gnt",   GNT,         32'h7);
    check("rst_busy",  bus_busy,    0);
    check("rst_owner", bus_owner,   0);
    check("rst_tmo",   gnt_timeout, 0);
    model_reset();
    frame_left = 0; irdy_left = 0; frame_drv = 1'b1; irdy_drv = 1'b1;
    step(); step();
    #2 rst = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: compare every registered output against the queued expectation.
  exp_t          mon_e;
  logic [NM-1:0] gnt_prev = '1, gnt_before;
  bit            fr_low_s;

  always @(posedge clk) begin
    fr_low_s   = (frame_w === 1'b0);
    gnt_before = GNT;
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("gnt",         GNT,         32'(mon_e.gnt));
      check("bus_owner",   bus_owner,   32'(mon_e.owner));
      check("bus_busy",    bus_busy,    32'(mon_e.busy));
      check("gnt_timeout", gnt_timeout, 32'(mon_e.tmo));
    end
    if (!rst) begin
      check("one_hot_gnt", ($countones(~GNT) <= 1), 1);
      if (fr_low_s) check("gnt_stable_frame", GNT, 32'(gnt_before));
      if (gnt_prev == '1 && GNT != '1) grant_log.push_back(int'(bus_owner));
    end
    gnt_prev = GNT;
  end

  initial begin
    rst = 1'b1; req_v = '1; req_in = '1; silent = '0; dev_auto = 1; rand_len = 0;
    lines_en = 1'b1; frame_drv = 1'b1; irdy_drv = 1'b1; frame_left = 0; irdy_left = 0;
    model_reset();
    #1;
    check("por_gnt",  GNT,      32'h7);
    check("por_busy", bus_busy, 0);
    step(); step();
    #2 rst = 1'b0;

    // Single requester 0 gets GNT one edge later.
    req_v = 3'b110; step();
    req_v = 3'b111; run(10);

    // All request: order 0,1,2,0 with a turnaround between transfers.
    async_reset(2);
    grant_log.delete();
    req_v = 3'b000; run(28);
    check("order_len", (grant_log.size() >= 4), 1);
    if (grant_log.size() >= 4) begin
      check("order0", grant_log[0], 0);
      check("order1", grant_log[1], 1);
      check("order2", grant_log[2], 2);
      check("order3", grant_log[3], 0);
    end

    // Master 1 silent: revoked after the timeout, then 2 is served.
    async_reset(3);
    grant_log.delete();
    silent = 3'b010; req_v = 3'b001; run(26);
    check("tmo_first", (grant_log.size() >= 2) ? grant_log[0] : -1, 1);
    check("tmo_next",  (grant_log.size() >= 2) ? grant_log[1] : -1, 2);
    silent = '0; req_v = '1; run(8);

    // Device 2 withdraws REQ mid-transfer; GNT held until the bus is idle.
    async_reset(1);
    req_v = 3'b011;
    for (int i = 0; i < 20 && !m_xfer; i++) step();
    check("wait_busy_2", m_xfer, 1);
    req_v = 3'b111; run(8);

    // Reset in the middle of a transfer, then a fresh grant.
    async_reset(2);
    req_v = 3'b000;
    for (int i = 0; i < 20 && !m_xfer; i++) step();
    check("wait_busy_rst", m_xfer, 1);
    step();
    async_reset(3);
    req_v = 3'b011; run(4);
    req_v = 3'b111; run(6);

    // Floating FRAME/IRDY read as idle.
    async_reset(4);
    dev_auto = 0; lines_en = 1'b0;
    req_v = 3'b101; run(22);
    req_v = 3'b111; run(3);
    lines_en = 1'b1; dev_auto = 1;

    // Randomised traffic.
    async_reset(2);
    rand_len = 1;
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        req_v  = NM'($urandom_range(0, 7));
        silent = NM'($urandom_range(0, 7)) & NM'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 249) == 0) async_reset(int'($urandom_range(1, 4)));
      else step();
    end
    req_v = '1; run(25);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
